dst7_transpose_buffer: RTL and testbench

Inter-pass transpose stage for the 2-D DST-VII datapath. Sits directly downstream of `dst7_1d`: accepts the M×M block of first-pass coefficients one row per cycle, applies the inter-pass rounding shift and clip, and replays the block column by column for the second 1-D pass. Block sizes are M = 4, 8, 16 and 32, selected by the same 2-bit `N` code as `dst7_1d`.

---
 rtl/dst7_pkg.sv | 17 +
 rtl/dst7_round_sat.sv | 44 ++++
 rtl/dst7_transpose_buffer.sv | 138 +++++++++++++
 tb/tb_dst7_transpose_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dst7_pkg.sv
// rtl/dst7_pkg.sv - shared lane count, block-size helper and FSM states for the DST-VII transpose stage
package dst7_pkg;

  localparam int LANES = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Block edge length M for the 2-bit size code: 0->4, 1->8, 2->16, 3->32.
  function automatic logic [5:0] dst7_size(input logic [1:0] n);
    return 6'd4 << n;
  endfunction

endpackage

// File: rtl/dst7_round_sat.sv
// rtl/dst7_round_sat.sv - one lane of round-half-up right shift followed by signed saturation
module dst7_round_sat #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6
) (
  input  logic signed [IN_W-1:0]  x_i,
  output logic signed [OUT_W-1:0] y_o
);

  // One guard bit so the rounding offset can never overflow the sum.
  localparam int TW = IN_W + 1;
  // Comparison width wide enough for both the shifted value and the clip bounds.
  localparam int EW = (TW > OUT_W) ? TW : OUT_W;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  logic signed [TW-1:0] xe;
  logic signed [TW-1:0] t;
  logic signed [EW-1:0] te;

  assign xe = {x_i[IN_W-1], x_i};

  if (SHIFT == 0) begin : g_pass
    assign t = xe;
  end else begin : g_rnd
    localparam logic signed [TW-1:0] RND = TW'(1) << (SHIFT - 1);
    assign t = (xe + RND) >>> SHIFT;
  end

  assign te = EW'(t);

  // Clamp the rounded value into the signed output range.
  always_comb begin
    if (te > MAX_V) begin
      y_o = MAX_V[OUT_W-1:0];
    end else if (te < MIN_V) begin
      y_o = MIN_V[OUT_W-1:0];
    end else begin
      y_o = te[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/dst7_transpose_buffer.sv
// rtl/dst7_transpose_buffer.sv - row-in / column-out transpose buffer between the two DST-VII passes
module dst7_transpose_buffer #(
  parameter int LANES = dst7_pkg::LANES,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_N,
  input  logic [LANES*IN_W-1:0]  in_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_N,
  output logic [LANES*OUT_W-1:0] out_col,
  output logic                   out_last,
  output logic                   busy
);

  import dst7_pkg::*;

  localparam int CW = $clog2(LANES);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        n_q, n_d;
  logic [OUT_W-1:0]  mem_q [LANES][LANES];

  logic [LANES*OUT_W-1:0] row_rs;
  logic [1:0]             wr_n;
  logic [5:0]             rd_size;
  logic [CW-1:0]          wr_last;
  logic [CW-1:0]          rd_last;
  logic [CW-1:0]          wr_row;
  logic                   wr_en;

  // Row 0 takes its size from the live input; later rows use the latched code.
  assign wr_n    = (state_q == IDLE) ? in_N : n_q;
  assign rd_size = dst7_size(n_q);
  assign wr_last = CW'(dst7_size(wr_n) - 6'd1);
  assign rd_last = CW'(rd_size - 6'd1);
  assign wr_row  = (state_q == IDLE) ? '0 : cnt_q;
  assign wr_en   = in_valid && in_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dst7_round_sat #(
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .SHIFT(SHIFT)
    ) u_round_sat (
      .x_i(in_row[k*IN_W +: IN_W]),
      .y_o(row_rs[k*OUT_W +: OUT_W])
    );
  end

  // Next-state, shared row/column counter and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    in_ready  = !rst && (state_q != DRAIN);
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && (cnt_q == rd_last);
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          n_d     = in_N;
          cnt_d   = CW'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (wr_en) begin
          if (cnt_q == wr_last) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (cnt_q == rd_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and latched size code; a reset discards any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  // Store the rounded and clipped row; contents are only ever read while draining.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        mem_q[wr_row][k] <= row_rs[k*OUT_W +: OUT_W];
      end
    end
  end

  // Present column cnt_q of the stored block, zero outside the block and outside DRAIN.
  always_comb begin
    out_col = '0;
    if (state_q == DRAIN) begin
      for (int k = 0; k < LANES; k++) begin
        if (k < int'(rd_size)) begin
          out_col[k*OUT_W +: OUT_W] = mem_q[k][cnt_q];
        end
      end
    end
  end

  assign out_N = n_q;

endmodule

// File: tb/tb_dst7_transpose_buffer.sv
// tb/tb_dst7_transpose_buffer.sv - self-checking bench for dst7_transpose_buffer
module tb_dst7_transpose_buffer;

  localparam int L  = 32;
  localparam int IW = 16;

  typedef struct { int n; int gap; int v[L]; } row_t;
  typedef struct { int v[L]; } col_t;
  typedef struct { logic [511:0] a; logic [511:0] b; logic last; int n; int cyc; } cap_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [1:0]       in_N = 2'd0;
  logic [L*IW-1:0]  in_row = '0;

  logic             in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [1:0]       out_N_a;
  logic [L*16-1:0]  out_col_a;
  logic             in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [1:0]       out_N_b;
  logic [L*8-1:0]   out_col_b;

  always #5 clk = ~clk;

  dst7_transpose_buffer u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_N(in_N),
    .in_row(in_row), .out_valid(out_valid_a), .out_ready(out_ready), .out_N(out_N_a),
    .out_col(out_col_a), .out_last(out_last_a), .busy(busy_a)
  );

  dst7_transpose_buffer #(.OUT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_N(in_N),
    .in_row(in_row), .out_valid(out_valid_b), .out_ready(out_ready), .out_N(out_N_b),
    .out_col(out_col_b), .out_last(out_last_b), .busy(busy_b)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  bit   toggle_rdy = 1'b0;
  int   drain_in_ready = 0;

  row_t src_q[$];
  col_t cols_q[$];
  cap_t cap_q[$];
  int   acc_q[$];
  int   blk[L][L];
  int   rows_got = 0;
  int   m_M = 4;
  int   m_N = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Rounded shift by 6 then clip to a signed outw-bit range.
  function automatic int rs(input int x, input int outw);
    longint t;
    longint hi;
    t  = (longint'(x) + 64'sd32) >>> 6;
    hi = (64'sd1 <<< (outw - 1)) - 64'sd1;
    if (t > hi) t = hi;
    if (t < -hi - 64'sd1) t = -hi - 64'sd1;
    return int'(t);
  endfunction

  function automatic logic [511:0] exp_col(input int outw);
    logic [511:0] r;
    int y;
    r = '0;
    if (cols_q.size() > 0) begin
      for (int k = 0; k < L; k++) begin
        y = rs(cols_q[0].v[k], outw);
        for (int b = 0; b < outw; b++) r[k*outw+b] = y[b];
      end
    end
    return r;
  endfunction

  function automatic int lane_a(input logic [511:0] v, input int k);
    return int'($signed(v[k*16 +: 16]));
  endfunction

  function automatic int lane_b(input logic [511:0] v, input int k);
    return int'($signed(v[k*8 +: 8]));
  endfunction

  function automatic int gen(input int kind, input int r, input int k, input int m);
    if (k >= m) return int'($signed(16'($urandom)));
    case (kind)
      0: return 64 * (4 * r + k);
      1: begin
        if (k != 0) return 0;
        case (r)
          0: return 32;
          1: return -32;
          2: return -33;
          default: return 31;
        endcase
      end
      2: begin
        if (k == 0 && r == 0) return 32767;
        if (k == 0 && r == 1) return -32768;
        return k - r;
      end
      default: return ((r * 37 + k * 11) % 2048 - 1024) * 16;
    endcase
  endfunction

  task automatic add_row(input int n, input int gap, input int r, input int kind);
    row_t e;
    e.n   = n;
    e.gap = gap;
    for (int k = 0; k < L; k++) e.v[k] = gen(kind, r, k, 4 << n);
    src_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(src_q.size() == 0 && rows_got == 0 && cols_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for block actual=%0d expected<%0d", n, budget);
    end
    @(negedge clk);
    #2;
  endtask

  // Block-level model: collect M rows, then expose their transpose as a column queue.
  always @(posedge clk) begin : model_p
    col_t cc;
    cyc = cyc + 1;
    if (rst) begin
      rows_got = 0;
      m_N = 0;
      cols_q.delete();
    end else if (cols_q.size() > 0) begin
      if (out_ready) void'(cols_q.pop_front());
    end else if (in_valid) begin
      if (rows_got == 0) begin
        m_N = int'(in_N);
        m_M = 4 << in_N;
      end
      for (int k = 0; k < L; k++) blk[rows_got][k] = int'($signed(in_row[k*IW +: IW]));
      rows_got = rows_got + 1;
      void'(src_q.pop_front());
      if (rows_got == m_M) begin
        for (int c = 0; c < m_M; c++) begin
          for (int k = 0; k < L; k++) cc.v[k] = (k < m_M) ? blk[k][c] : 0;
          cols_q.push_back(cc);
        end
        rows_got = 0;
      end
    end
  end

  // Drive inputs on the falling edge, then compare every output against the model.
  initial forever begin
    cap_t cp;
    @(negedge clk);
    if (src_q.size() > 0 && src_q[0].gap > 0) begin
      in_valid = 1'b0;
      src_q[0].gap = src_q[0].gap - 1;
      for (int k = 0; k < L; k++) in_row[k*IW +: IW] = 16'($urandom);
    end else if (src_q.size() > 0) begin
      in_valid = 1'b1;
      in_N = 2'(src_q[0].n);
      for (int k = 0; k < L; k++) in_row[k*IW +: IW] = 16'(src_q[0].v[k]);
    end else begin
      in_valid = 1'b0;
      for (int k = 0; k < L; k++) in_row[k*IW +: IW] = 16'($urandom);
    end
    out_ready = toggle_rdy ? ~out_ready : 1'b1;
    #1;
    if (chk_en) begin
      chk_b("in_ready", in_ready_a, !rst && cols_q.size() == 0);
      chk_b("out_valid", out_valid_a, cols_q.size() > 0);
      chk_b("out_last", out_last_a, cols_q.size() == 1);
      chk_b("busy", busy_a, rows_got > 0 || cols_q.size() > 0);
      chk_i("out_N", int'(out_N_a), m_N);
      chk_v("out_col", {out_col_a}, exp_col(16));
      chk_b("out_valid_b", out_valid_b, cols_q.size() > 0);
      chk_b("out_last_b", out_last_b, cols_q.size() == 1);
      chk_v("out_col_b", {256'b0, out_col_b}, exp_col(8));
    end
    if (out_valid_a && out_ready) begin
      cp.a = out_col_a;
      cp.b = {256'b0, out_col_b};
      cp.last = out_last_a;
      cp.n = int'(out_N_a);
      cp.cyc = cyc;
      cap_q.push_back(cp);
    end
    if (in_valid && in_ready_a) acc_q.push_back(cyc);
    if (out_valid_a && in_ready_a) drain_in_ready++;
  end

  initial begin
    @(negedge clk);
    #2;
    chk_b("rst in_ready", in_ready_a, 1'b0);
    chk_b("rst out_valid", out_valid_a, 1'b0);
    chk_b("rst busy", busy_a, 1'b0);
    chk_b("rst out_last", out_last_a, 1'b0);
    chk_i("rst out_N", int'(out_N_a), 0);
    chk_v("rst out_col", {out_col_a}, '0);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_b("in_ready after rst", in_ready_a, 1'b1);

    // 4x4 transpose
    cap_q.delete(); acc_q.delete();
    for (int r = 0; r < 4; r++) add_row(0, 0, r, 0);
    wait_done(100);
    chk_i("t4 columns", cap_q.size(), 4);
    if (cap_q.size() == 4 && acc_q.size() == 4) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 4; k++) chk_i("t4 lane", lane_a(cap_q[c].a, k), 4 * k + c);
        chk_v("t4 upper lanes", cap_q[c].a >> 64, '0);
        chk_b("t4 last", cap_q[c].last, c == 3);
      end
      chk_i("t4 latency", cap_q[0].cyc - acc_q[3], 1);
      chk_i("t4 block span", cap_q[3].cyc - acc_q[0], 7);
    end

    // rounding
    cap_q.delete();
    for (int r = 0; r < 4; r++) add_row(0, 0, r, 1);
    wait_done(100);
    chk_i("rnd columns", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk_i("rnd 32", lane_a(cap_q[0].a, 0), 1);
      chk_i("rnd -32", lane_a(cap_q[0].a, 1), 0);
      chk_i("rnd -33", lane_a(cap_q[0].a, 2), -1);
      chk_i("rnd 31", lane_a(cap_q[0].a, 3), 0);
    end

    // saturation on the OUT_W=8 instance
    cap_q.delete();
    for (int r = 0; r < 4; r++) add_row(0, 0, r, 2);
    wait_done(100);
    chk_i("sat columns", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk_i("sat hi w8", lane_b(cap_q[0].b, 0), 127);
      chk_i("sat lo w8", lane_b(cap_q[0].b, 1), -128);
      chk_i("sat hi w16", lane_a(cap_q[0].a, 0), 512);
      chk_i("sat lo w16", lane_a(cap_q[0].a, 1), -512);
    end

    // 32x32 with output backpressure
    cap_q.delete(); drain_in_ready = 0; toggle_rdy = 1'b1;
    for (int r = 0; r < 32; r++) add_row(3, 0, r, 3);
    wait_done(400);
    toggle_rdy = 1'b0;
    chk_i("t32 columns", cap_q.size(), 32);
    chk_i("t32 in_ready in drain", drain_in_ready, 0);
    if (cap_q.size() == 32) begin
      for (int c = 0; c < 32; c++) chk_b("t32 last", cap_q[c].last, c == 31);
      chk_i("t32 col5 lane0", lane_a(cap_q[5].a, 0), -242);
      chk_i("t32 col31 lane31", lane_a(cap_q[31].a, 31), 116);
    end

    // size latch with input gaps and garbage upper lanes
    cap_q.delete(); acc_q.delete();
    for (int r = 0; r < 8; r++) add_row((r < 3) ? 1 : 3, (r % 3 == 1) ? 2 : 0, r, 3);
    wait_done(200);
    chk_i("latch rows", acc_q.size(), 8);
    chk_i("latch columns", cap_q.size(), 8);
    if (cap_q.size() == 8) begin
      chk_i("latch out_N", cap_q[0].n, 1);
      for (int c = 0; c < 8; c++) chk_v("latch upper lanes", cap_q[c].a >> 128, '0);
      chk_b("latch last", cap_q[7].last, 1'b1);
    end

    // reset after 5 of 16 rows
    for (int r = 0; r < 5; r++) add_row(2, 0, r, 3);
    for (int i = 0; i < 50 && src_q.size() > 0; i++) @(negedge clk);
    chk_i("pre-rst rows left", src_q.size(), 0);
    #2;
    chk_b("pre-rst busy", busy_a, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_b("mid rst busy", busy_a, 1'b0);
    chk_b("mid rst in_ready", in_ready_a, 1'b0);
    chk_b("mid rst out_valid", out_valid_a, 1'b0);
    chk_i("mid rst out_N", int'(out_N_a), 0);
    chk_v("mid rst out_col", {out_col_a}, '0);
    @(negedge clk);
    rst = 1'b0;

    // back-to-back 16x16 then 4x4
    cap_q.delete(); acc_q.delete();
    for (int r = 0; r < 16; r++) add_row(2, 0, r, 3);
    for (int r = 0; r < 4; r++) add_row(0, 0, r, 3);
    wait_done(300);
    chk_i("b2b rows", acc_q.size(), 20);
    chk_i("b2b columns", cap_q.size(), 20);
    if (acc_q.size() == 20 && cap_q.size() == 20) begin
      chk_i("b2b second block start", acc_q[16] - acc_q[0], 32);
      chk_b("b2b last 16", cap_q[15].last, 1'b1);
      chk_b("b2b last 4", cap_q[19].last, 1'b1);
      chk_i("b2b t16 col0 lane1", lane_a(cap_q[0].a, 1), -247);
      chk_i("b2b t4 col2 lane3", lane_a(cap_q[18].a, 3), -223);
      chk_i("b2b t4 out_N", cap_q[16].n, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
